// File: rtl/mlp_feature_loader_if.sv
// rtl/mlp_feature_loader_if.sv - feature stream and result stream bundle for mlp_feature_loader
// Purpose: groups the feature input handshake and the class result handshake.
// Signals:
//   feat_valid/feat_ready/feat_data/feat_last : feature stream, source -> loader
//   res_valid/res_ready/res_class/res_err     : result stream, loader -> consumer
// Modports: slave = loader side, master = source/consumer side.
interface mlp_feature_loader_if #(
  parameter int FEAT_W = 4,
  parameter int CLS_W  = 2
);
  logic              feat_valid;
  logic              feat_ready;
  logic [FEAT_W-1:0] feat_data;
  logic              feat_last;
  logic              res_valid;
  logic              res_ready;
  logic [CLS_W-1:0]  res_class;
  logic              res_err;

  modport slave (
    input  feat_valid, feat_data, feat_last, res_ready,
    output feat_ready, res_valid, res_class, res_err
  );

  modport master (
    output feat_valid, feat_data, feat_last, res_ready,
    input  feat_ready, res_valid, res_class, res_err
  );
endinterface

// File: rtl/mlp_feature_loader.sv
// rtl/mlp_feature_loader.sv - sequential feature packer and result capture for a combinational MLP
// Purpose: packs FEAT_W-bit features into a held N_FEAT*FEAT_W vector, waits SETTLE_CYC
//          cycles for the classifier, captures its class index and returns it with a
//          framing-error flag; counts completed result handshakes.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : feature stream in, result stream out
//   mlp_inp_o    : packed vector to classifier input (feature 0 in LSBs)
//   mlp_out_i    : class index from classifier
//   class_cnt_o  : completed result handshakes, wraps
module mlp_feature_loader #(
  parameter int N_FEAT     = 8,
  parameter int FEAT_W     = 4,
  parameter int CLS_W      = 2,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  mlp_feature_loader_if.slave      bus,
  output logic [N_FEAT*FEAT_W-1:0] mlp_inp_o,
  input  logic [CLS_W-1:0]         mlp_out_i,
  output logic [CNT_W-1:0]         class_cnt_o
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_FEAT - 1);
  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [7:0]                settle_q, settle_d;
  logic                      err_q, err_d;
  logic [N_FEAT*FEAT_W-1:0]  inp_q, inp_d;
  logic                      res_valid_q, res_valid_d;
  logic [CLS_W-1:0]          res_class_q, res_class_d;
  logic                      res_err_q, res_err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      is_last_slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      settle_q    <= '0;
      err_q       <= 1'b0;
      inp_q       <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      inp_q       <= inp_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign is_last_slot = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    err_d       = err_q;
    inp_d       = inp_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_LOAD: begin
        if (bus.feat_valid) begin
          inp_d[idx_q*FEAT_W +: FEAT_W] = bus.feat_data;
          if (is_last_slot || bus.feat_last) begin
            state_d  = S_SETTLE;
            settle_d = SETTLE_INIT;
            // A frame is well formed only when last coincides with the final slot;
            // an early last or a missing last both flag the frame.
            if (bus.feat_last != is_last_slot) begin
              err_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == 8'd0) begin
          res_class_d = mlp_out_i;
          res_err_d   = err_q;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_RESULT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = cnt_q + 1'b1;
          idx_d       = '0;
          err_d       = 1'b0;
          inp_d       = '0;
          state_d     = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Ready depends only on state; held low while reset is asserted.
  assign bus.feat_ready = (state_q == S_LOAD) && !rst;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_class  = res_class_q;
  assign bus.res_err    = res_err_q;
  assign mlp_inp_o      = inp_q;
  assign class_cnt_o    = cnt_q;

endmodule

// File: tb/tb_mlp_feature_loader.sv
// tb/tb_mlp_feature_loader.sv - scoreboard bench for mlp_feature_loader
module tb_mlp_feature_loader;
  localparam int SETTLE_CYC = 2;

  typedef struct {
    logic [31:0] vec;
    logic [1:0]  cls;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mlp_inp, mlp_inp2;
  logic [1:0]  mlp_out;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic        rr = 1'b0;
  logic        rr_hold = 1'b1;
  logic        rr_val = 1'b0;
  logic        stub_mode = 1'b0;
  logic [1:0]  stub_val = 2'd0;
  logic [7:0]  nib_sum;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   cnt_seen = 0;
  logic rv_prev = 1'b0;
  exp_t q[$];

  logic [31:0] m_vec = '0;
  int          m_sum = 0;
  int          m_k = 0;
  logic [3:0]  fbuf [0:8];

  mlp_feature_loader_if #(.FEAT_W(4), .CLS_W(2)) bus ();
  mlp_feature_loader_if #(.FEAT_W(4), .CLS_W(2)) bus2 ();

  mlp_feature_loader #(.N_FEAT(8), .FEAT_W(4), .CLS_W(2), .SETTLE_CYC(SETTLE_CYC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mlp_inp_o(mlp_inp), .mlp_out_i(mlp_out), .class_cnt_o(cnt)
  );

  // Narrow-counter copy fed the identical stimulus, used for the wrap check.
  mlp_feature_loader #(.N_FEAT(8), .FEAT_W(4), .CLS_W(2), .SETTLE_CYC(SETTLE_CYC), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .mlp_inp_o(mlp_inp2), .mlp_out_i(mlp_out), .class_cnt_o(cnt2)
  );

  assign bus.res_ready   = rr;
  assign bus2.feat_valid = bus.feat_valid;
  assign bus2.feat_data  = bus.feat_data;
  assign bus2.feat_last  = bus.feat_last;
  assign bus2.res_ready  = rr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Classifier stand-in: sum of nibbles mod 4, or a fixed stub value.
  always_comb begin
    nib_sum = 8'd0;
    for (int i = 0; i < 8; i++) nib_sum = nib_sum + 8'(mlp_inp[i*4 +: 4]);
    mlp_out = stub_mode ? stub_val : nib_sum[1:0];
  end

  always @(posedge clk) begin
    #1;
    if (rr_hold) rr = rr_val;
    else         rr = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame closes on last or on the 8th feature, and is clean
  // only when exactly 8 features arrived with last on the 8th.
  task automatic model_accept(input logic [3:0] d, input logic last);
    exp_t e;
    m_vec[m_k*4 +: 4] = d;
    m_sum = m_sum + int'(d);
    m_k++;
    if (last || m_k == 8) begin
      e.vec = m_vec;
      e.cls = stub_mode ? stub_val : 2'(m_sum % 4);
      e.err = !(m_k == 8 && last);
      q.push_back(e);
      last_acc_cyc = cyc + 1;
      m_vec = '0;
      m_sum = 0;
      m_k = 0;
    end
  endtask

  task automatic send_feat(input logic [3:0] d, input logic last, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.feat_valid = 1'b1;
    bus.feat_data  = d;
    bus.feat_last  = last;
    t = 0;
    while (!bus.feat_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.feat_ready) begin
      chk("feat_accept_timeout", 32'd0, 32'd1);
      bus.feat_valid = 1'b0;
    end else begin
      model_accept(d, last);
      @(posedge clk);
      #1;
      bus.feat_valid = 1'b0;
    end
  endtask

  task automatic send_list(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_feat(fbuf[i], (i == last_at), 0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.res_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(q.size() != 0 || bus.res_valid), 32'd0);
  endtask

  task automatic wait_res_valid();
    int t;
    t = 0;
    while (!bus.res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid_timeout", 32'(bus.res_valid), 32'd1);
  endtask

  // Monitor: vector and latency at result rise, class/err/counters at handshake.
  always @(negedge clk) begin
    if (rst) begin
      rv_prev = 1'b0;
    end else begin
      if (bus.res_valid) chk("feat_ready_in_result", 32'(bus.feat_ready), 32'd0);
      if (bus.res_valid && !rv_prev) begin
        chk("latency", 32'(cyc - last_acc_cyc), 32'(SETTLE_CYC));
        if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else               chk("mlp_inp", mlp_inp, q[0].vec);
      end
      if (bus.res_valid && bus.res_ready && q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("res_class", 32'(bus.res_class), 32'(e.cls));
        chk("res_err", 32'(bus.res_err), 32'(e.err));
        chk("class_cnt", 32'(cnt), 32'(cnt_seen % 65536));
        chk("class_cnt_wrap", 32'(cnt2), 32'(cnt_seen % 4));
        cnt_seen++;
      end
      rv_prev = bus.res_valid;
    end
  end

  initial begin
    int n;
    logic miss;
    rst = 1'b1;
    bus.feat_valid = 1'b0;
    bus.feat_data  = 4'd0;
    bus.feat_last  = 1'b0;
    rr_hold = 1'b1;
    rr_val  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_feat_ready", 32'(bus.feat_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_mlp_inp", mlp_inp, 32'd0);
    chk("rst_class_cnt", 32'(cnt), 32'd0);
    chk("rst_res_class", 32'(bus.res_class), 32'd0);
    chk("rst_res_err", 32'(bus.res_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("load_feat_ready", 32'(bus.feat_ready), 32'd1);

    // All-zero frame.
    for (int i = 0; i < 9; i++) fbuf[i] = 4'd0;
    send_list(8, 7);
    wait_idle();

    // Stub classifier, features 1..8.
    stub_mode = 1'b1;
    stub_val  = 2'b10;
    for (int i = 0; i < 8; i++) fbuf[i] = 4'(i + 1);
    send_list(8, 7);
    wait_idle();
    stub_mode = 1'b0;

    // Short frame then a clean frame.
    fbuf[0] = 4'hF;
    fbuf[1] = 4'hA;
    send_list(2, 1);
    wait_idle();
    for (int i = 0; i < 8; i++) fbuf[i] = 4'($urandom_range(0, 15));
    send_list(8, 7);
    wait_idle();

    // Missing last: 8 closes the frame, the 9th starts a one-feature frame.
    for (int i = 0; i < 9; i++) fbuf[i] = 4'($urandom_range(0, 15));
    send_list(8, -1);
    send_feat(fbuf[8], 1'b1, 0);
    wait_idle();

    // Result backpressure with features pending.
    rr_val = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) fbuf[i] = 4'($urandom_range(0, 15));
    send_list(8, 7);
    wait_res_valid();
    for (int i = 0; i < 10; i++) begin
      bus.feat_valid = 1'b1;
      bus.feat_data  = 4'($urandom_range(0, 15));
      bus.feat_last  = 1'b1;
      chk("bp_feat_ready", 32'(bus.feat_ready), 32'd0);
      chk("bp_res_class", 32'(bus.res_class), (q.size() != 0) ? 32'(q[0].cls) : 32'hFFFF);
      @(negedge clk);
    end
    bus.feat_valid = 1'b0;
    rr_val = 1'b1;
    @(negedge clk);
    rr_val = 1'b0;
    @(negedge clk);
    chk("bp_feat_ready_after", 32'(bus.feat_ready), 32'd1);
    chk("bp_res_valid_after", 32'(bus.res_valid), 32'd0);

    // Reset while a result is pending.
    for (int i = 0; i < 8; i++) fbuf[i] = 4'($urandom_range(1, 15));
    send_list(8, 7);
    wait_res_valid();
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_mlp_inp", mlp_inp, 32'd0);
    chk("midrst_class_cnt", 32'(cnt), 32'd0);
    chk("midrst_feat_ready", 32'(bus.feat_ready), 32'd0);
    q.delete();
    cnt_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    rr_val = 1'b1;

    // Randomised frames with random result backpressure.
    rr_hold = 1'b0;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 8);
      miss = (n == 8) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++)
        send_feat(4'($urandom_range(0, 15)), (i == n - 1) && !miss, $urandom_range(0, 2));
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule

// File: doc/mlp_feature_loader.md
Name: mlp_feature_loader

Overview:
- Sequential front/back end for the combinational printed-MLP classifier.
- Accepts 4-bit input features one per handshake and assembles them into the classifier's packed 32-bit input vector, holding that vector stable.
- Waits a programmable settle time for the slow combinational classifier, captures its 2-bit class index, and returns it over a valid/ready result interface.
- Flags framing errors and counts completed classifications.

Parameters:
- N_FEAT, 8, features per frame (classifier input count).
- FEAT_W, 4, bits per feature.
- CLS_W, 2, class index width.
- SETTLE_CYC, 2, cycles the vector is held before sampling the class; legal range 1..255.
- CNT_W, 16, width of the classification counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- feat_valid  in  1  feature source has a feature.
- feat_ready  out  1  loader accepts a feature this cycle.
- feat_data  in  FEAT_W  feature value (unsigned).
- feat_last  in  1  marks the final feature of a frame.
- mlp_inp  out  N_FEAT*FEAT_W  packed vector to the classifier's inp.
- mlp_out  in  CLS_W  class index from the classifier's out.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_class  out  CLS_W  captured class index.
- res_err  out  1  frame had a framing error; qualified by res_valid.
- class_cnt  out  CNT_W  completed result handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): state=LOAD, idx=0, mlp_inp=0, res_valid=0, res_class=0, res_err=0, class_cnt=0, feat_ready=0 while rst is high.
- Packing: feature k of a frame is written to mlp_inp[k*FEAT_W +: FEAT_W]; feature 0 goes in the LSBs.
- Unwritten slots stay 0.
- mlp_inp is registered and changes only on feature accept or on the clear when returning to LOAD.

FSM:
- LOAD: feat_ready=1, res_valid=0.
  - On feat_valid&feat_ready, write slot idx.
  - If idx==N_FEAT-1 or feat_last=1: go to SETTLE with settle_cnt=SETTLE_CYC-1. Otherwise idx++.
  - Error latch: err=1 if feat_last=1 with idx<N_FEAT-1 (short frame; remaining slots 0).
  - Error latch: err=1 if idx==N_FEAT-1 and feat_last=0 (missing last; frame still closes).
- SETTLE: feat_ready=0, mlp_inp frozen.
  - If settle_cnt==0: at this edge res_class<=mlp_out, res_err<=err, res_valid<=1, go to RESULT.
  - Else settle_cnt--.
- RESULT: feat_ready=0, res_valid=1; res_class and res_err stable.
  - On res_ready: res_valid<=0, class_cnt++, idx<=0, err<=0, mlp_inp<=0, go to LOAD.
- Latency: res_valid rises exactly SETTLE_CYC cycles after the edge accepting the final feature.
- Minimum frame period: N_FEAT + SETTLE_CYC + 1 cycles with res_ready held high.
- Feature backpressure: feat_valid is ignored outside LOAD. feat_data/feat_last are sampled only when feat_valid&feat_ready.
- res_ready while res_valid=0 has no effect.
- feat_ready is combinational from state only, with no dependence on feat_valid.
- class_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset during SETTLE or RESULT: frame discarded, all outputs return to reset values, class_cnt cleared.
- Single-feature frame: feat_last on the first feature is legal. It goes to SETTLE with slot 0 written and err=1 when N_FEAT>1.

Test Plan:
- Reset mid-RESULT (res_valid=1): assert rst -> res_valid=0, mlp_inp=0, class_cnt=0 in the same cycle; next frame is processed normally.
- Real classifier attached, 8 zero features, last on the 8th, SETTLE_CYC=2, res_ready=1 -> mlp_inp=0x00000000, res_valid 2 cycles after the last accept, res_class=0, res_err=0, class_cnt=1.
- Stub classifier returning 2'b10, features 1..8 in order, last on the 8th -> mlp_inp=0x87654321 during SETTLE, res_class=2, res_err=0.
- Short frame: features 0xF,0xA with last on the 2nd -> mlp_inp=0x000000AF, res_err=1; the next clean frame reports res_err=0.
- Missing last on the 8th feature -> frame closes anyway, res_err=1, and the 9th feat_valid is not accepted until LOAD.
- Backpressure: hold res_ready=0 for 10 cycles with feat_valid=1 -> feat_ready=0 and res_class stable throughout; one res_ready pulse -> class_cnt +1, feat_ready=1 on the next cycle.
- Wrap: CNT_W=2, complete 5 frames -> class_cnt reads 1.
